// File: rtl/snake_pkg.sv
// Shared constants for the snake game blocks.
//   LFSR_WIDTH   : width of the game PRNG state
//   LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   DEFAULT_SEED : power-up / restart value of the PRNG
//   BOARD_IDX_W  : width of a cell index on the 64-cell board
package snake_pkg;

   localparam int unsigned LFSR_WIDTH = 16;
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;
   localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 16'hACE1;
   localparam int unsigned BOARD_IDX_W = 6;

endpackage : snake_pkg

// File: rtl/prng_lfsr_step.sv
// One step of the 16-bit right-shifting Galois LFSR (purely combinational).
//   lfsr : current state
//   next : state after one shift
module prng_lfsr_step
   import snake_pkg::*;
(
   input  logic [LFSR_WIDTH-1:0] lfsr,
   output logic [LFSR_WIDTH-1:0] next
);

   // Bit shifted out of the bottom feeds back through the tap mask.
   always_comb begin
      next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
   end

endmodule : prng_lfsr_step

// File: rtl/snake_prng.sv
// Food-placement random source: LFSR advanced on request, registered output.
//   clka         : sole clock, rising edge
//   restart      : synchronous active-high reset, overrides request_rand
//   request_rand : advance LFSR and refresh random_num this cycle
//   random_num   : low OUT_WIDTH bits of the most recent LFSR state
module snake_prng
   import snake_pkg::*;
#(
   parameter logic [LFSR_WIDTH-1:0] SEED      = DEFAULT_SEED,
   parameter int unsigned           OUT_WIDTH = BOARD_IDX_W
)
(
   input  logic                 clka,
   input  logic                 restart,
   input  logic                 request_rand,
   output logic [OUT_WIDTH-1:0] random_num
);

   // A zero seed would lock the LFSR, so fall back to the default.
   localparam logic [LFSR_WIDTH-1:0] EFF_SEED = (SEED == '0) ? DEFAULT_SEED : SEED;

   generate
      if (OUT_WIDTH < 1 || OUT_WIDTH > LFSR_WIDTH) begin : g_bad_width
         $error("snake_prng: OUT_WIDTH must be in 1..16");
      end
   endgenerate

   logic [LFSR_WIDTH-1:0] lfsr;
   logic [LFSR_WIDTH-1:0] next;
   logic [OUT_WIDTH-1:0]  out_reg;

   prng_lfsr_step u_step (
      .lfsr (lfsr),
      .next (next)
   );

   // Restart first, then request; an all-zero state reseeds instead of stepping.
   always_ff @(posedge clka) begin
      if (restart) begin
         lfsr    <= EFF_SEED;
         out_reg <= '0;
      end else if (request_rand) begin
         if (lfsr == '0) begin
            lfsr    <= EFF_SEED;
            out_reg <= EFF_SEED[OUT_WIDTH-1:0];
         end else begin
            lfsr    <= next;
            out_reg <= next[OUT_WIDTH-1:0];
         end
      end
   end

   assign random_num = out_reg;

endmodule : snake_prng

// File: tb/tb_snake_prng.sv
// Self-checking bench for snake_prng: directed sequence, random mix against a
// behavioural model, full-period sweep and lock-up recovery.
module tb_snake_prng;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam int unsigned OW   = 6;

   logic          clka = 1'b0;
   logic          restart = 1'b1;
   logic          request_rand = 1'b0;
   logic [OW-1:0] random_num;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: the value the LFSR should hold and the visible number.
   int m_lfsr;
   int m_out;

   snake_prng #(.SEED(SEED), .OUT_WIDTH(OW)) dut (
      .clka         (clka),
      .restart      (restart),
      .request_rand (request_rand),
      .random_num   (random_num)
   );

   always #5 clka = ~clka;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Polynomial view: dividing by x in GF(2)[x]/p(x); an odd value first
   // cancels the constant term, then the reduced remainder folds in the taps.
   function automatic int model_next(input int v);
      if (v == 0)     return int'(SEED);
      if (v % 2 == 1) return (v / 2) ^ 'hB400;
      return v / 2;
   endfunction

   // Apply inputs for one cycle, advance the model, land on the next negedge.
   task automatic tick(input logic rs, input logic rq);
      restart      = rs;
      request_rand = rq;
      if (rs) begin
         m_lfsr = int'(SEED);
         m_out  = 0;
      end else if (rq) begin
         m_lfsr = model_next(m_lfsr);
         m_out  = m_lfsr % (1 << OW);
      end
      @(posedge clka);
      @(negedge clka);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_num"},  int'(random_num), m_out);
      check({tag, "_lfsr"}, int'(dut.lfsr),   m_lfsr);
   endtask

   initial begin
      logic [63:0] seen;
      int          zero_hits;
      int          first_ret;
      int          seen_cnt;

      m_lfsr = 0;
      m_out  = 0;
      @(negedge clka);

      // Reset and idle hold.
      tick(1'b1, 1'b0);
      check("rst_num", int'(random_num), 0);
      check("rst_lfsr", int'(dut.lfsr), 'hACE1);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0);
         check("idle_after_rst", int'(random_num), 0);
      end

      // Directed pulses with idle gaps.
      tick(1'b0, 1'b1);
      check("p1_lfsr", int'(dut.lfsr), 'hE270);
      check("p1_num", int'(random_num), 48);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0);
         check("p1_hold", int'(random_num), 48);
      end
      tick(1'b0, 1'b1);
      check("p2_lfsr", int'(dut.lfsr), 'h7138);
      check("p2_num", int'(random_num), 56);
      tick(1'b0, 1'b0);
      check("p2_hold", int'(random_num), 56);
      tick(1'b0, 1'b1);
      check("p3_lfsr", int'(dut.lfsr), 'h389C);
      check("p3_num", int'(random_num), 28);
      tick(1'b0, 1'b0);
      check("p3_hold", int'(random_num), 28);

      // Restart beats request, and the sequence replays.
      tick(1'b1, 1'b1);
      check("prio_num", int'(random_num), 0);
      check("prio_lfsr", int'(dut.lfsr), 'hACE1);
      tick(1'b0, 1'b1);
      check("replay_num", int'(random_num), 48);

      // Random mix of requests, idles and occasional restarts.
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
         check_model("rand");
      end

      // Full period from reset with request held.
      tick(1'b1, 1'b0);
      seen      = '0;
      zero_hits = 0;
      first_ret = -1;
      for (int i = 1; i <= 65535; i++) begin
         tick(1'b0, 1'b1);
         if (random_num !== m_out[OW-1:0]) check("period_num", int'(random_num), m_out);
         seen[random_num] = 1'b1;
         if (dut.lfsr == 16'h0) zero_hits++;
         if (first_ret < 0 && dut.lfsr == SEED) first_ret = i;
      end
      seen_cnt = 0;
      for (int b = 0; b < 64; b++) if (seen[b]) seen_cnt++;
      check("period_len", first_ret, 65535);
      check("period_end_lfsr", int'(dut.lfsr), 'hACE1);
      check("period_zero_hits", zero_hits, 0);
      check("period_hist", seen_cnt, 64);
      request_rand = 1'b0;

      // Lock-up recovery from an illegal all-zero state.
      tick(1'b0, 1'b0);
      force dut.lfsr = 16'h0000;
      #1;
      release dut.lfsr;
      check("zero_forced", int'(dut.lfsr), 0);
      tick(1'b0, 1'b1);
      check("zero_lfsr", int'(dut.lfsr), 'hACE1);
      check("zero_num", int'(random_num), 33);
      tick(1'b0, 1'b1);
      check("zero_next", int'(random_num), 48);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_snake_prng
